// File: rtl/proc_csr_io_unit.sv
// CSR I/O unit: CSRR input mux, a DEPTH-stage CSRW pipeline from X to commit,
// and a per-channel output handshake. Optional macro CSR_IO_READBACK_EN enables readback.
module proc_csr_io_unit #(
    parameter int NBITS = 32,
    parameter int N_IN  = 3,
    parameter int N_OUT = 3,
    parameter int DEPTH = 3,
    parameter int SELW  = $clog2(N_IN + N_OUT + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipe_en,
    input  logic                     kill_X,
    input  logic [SELW-1:0]          csrr_sel_D,
    input  logic [N_IN*NBITS-1:0]    in_data,
    output logic [NBITS-1:0]         csrr_data_X,
    input  logic                     csrw_val_D,
    input  logic [SELW-1:0]          csrw_sel_D,
    input  logic [NBITS-1:0]         csrw_data_D,
    output logic [N_OUT*NBITS-1:0]   out_data,
    output logic [N_OUT-1:0]         out_val,
    output logic [N_OUT-1:0]         out_pending,
    input  logic [N_OUT-1:0]         out_ack,
    output logic [N_OUT-1:0]         out_overrun
);

    logic [NBITS-1:0]       r_csrr_data;
    logic [DEPTH-1:0]       r_stg_val;
    logic [SELW-1:0]        r_stg_sel  [DEPTH];
    logic [NBITS-1:0]       r_stg_data [DEPTH];
    logic [N_OUT*NBITS-1:0] r_out_data;
    logic [N_OUT-1:0]       r_out_val;
    logic [N_OUT-1:0]       r_out_pending;
    logic [N_OUT-1:0]       r_out_overrun;

    logic [DEPTH-1:0]       w_adv_val;
    logic [N_OUT-1:0]       w_commit;
    logic [NBITS-1:0]       w_rd_data;

    // Stage valids as seen leaving this edge; a kill squashes the token sitting in X
    always_comb begin
        w_adv_val    = r_stg_val;
        w_adv_val[0] = r_stg_val[0] & ~kill_X;
    end

    // Per-channel commit strobe from the last stage on an advancing edge
    always_comb begin
        w_commit = {N_OUT{1'b0}};
        for (int k = 0; k < N_OUT; k++) begin
            if (pipe_en && w_adv_val[DEPTH-1] && (r_stg_sel[DEPTH-1] == SELW'(k))) begin
                w_commit[k] = 1'b1;
            end else begin
                w_commit[k] = 1'b0;
            end
        end
    end

    // CSRR source mux; out-of-range selects read as zero
    always_comb begin
        w_rd_data = {NBITS{1'b0}};
        for (int i = 0; i < N_IN; i++) begin
            w_rd_data = w_rd_data |
                ((csrr_sel_D == SELW'(i)) ? in_data[i*NBITS +: NBITS] : {NBITS{1'b0}});
        end
`ifdef CSR_IO_READBACK_EN
        for (int j = 0; j < N_OUT; j++) begin
            w_rd_data = w_rd_data |
                ((csrr_sel_D == SELW'(N_IN + j)) ? r_out_data[j*NBITS +: NBITS] : {NBITS{1'b0}});
        end
`endif
    end

    // CSRR operand register and write pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            r_csrr_data <= {NBITS{1'b0}};
            r_stg_val   <= {DEPTH{1'b0}};
            for (int k = 0; k < DEPTH; k++) begin
                r_stg_sel[k]  <= {SELW{1'b0}};
                r_stg_data[k] <= {NBITS{1'b0}};
            end
        end else if (pipe_en) begin
            r_csrr_data   <= w_rd_data;
            // The D token is dropped as well when X is squashed
            r_stg_val[0]  <= csrw_val_D & ~kill_X;
            r_stg_sel[0]  <= csrw_sel_D;
            r_stg_data[0] <= csrw_data_D;
            for (int k = 1; k < DEPTH; k++) begin
                r_stg_val[k]  <= w_adv_val[k-1];
                r_stg_sel[k]  <= r_stg_sel[k-1];
                r_stg_data[k] <= r_stg_data[k-1];
            end
        end else begin
            r_stg_val[0] <= w_adv_val[0];
        end
    end

    // Output registers and handshake flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data    <= {(N_OUT*NBITS){1'b0}};
            r_out_val     <= {N_OUT{1'b0}};
            r_out_pending <= {N_OUT{1'b0}};
            r_out_overrun <= {N_OUT{1'b0}};
        end else begin
            r_out_val <= w_commit;
            for (int k = 0; k < N_OUT; k++) begin
                if (w_commit[k]) begin
                    r_out_data[k*NBITS +: NBITS] <= r_stg_data[DEPTH-1];
                end
                r_out_pending[k] <= w_commit[k] | (r_out_pending[k] & ~out_ack[k]);
                // Commit racing an ack leaves overrun alone
                if (w_commit[k] && !out_ack[k]) begin
                    r_out_overrun[k] <= r_out_overrun[k] | r_out_pending[k];
                end else if (out_ack[k] && !w_commit[k]) begin
                    r_out_overrun[k] <= 1'b0;
                end
            end
        end
    end

    assign csrr_data_X = r_csrr_data;
    assign out_data    = r_out_data;
    assign out_val     = r_out_val;
    assign out_pending = r_out_pending;
    assign out_overrun = r_out_overrun;

endmodule

// File: tb/tb_proc_csr_io_unit.sv
// Self-checking bench for proc_csr_io_unit: token-countdown reference model plus directed vectors.
module tb_proc_csr_io_unit;

    localparam int NBITS = 32;
    localparam int N_IN  = 3;
    localparam int N_OUT = 3;
    localparam int DEPTH = 3;
    localparam int SELW  = $clog2(N_IN + N_OUT + 1);

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   pipe_en;
    logic                   kill_X;
    logic [SELW-1:0]        csrr_sel_D;
    logic [N_IN*NBITS-1:0]  in_data;
    logic [NBITS-1:0]       csrr_data_X;
    logic                   csrw_val_D;
    logic [SELW-1:0]        csrw_sel_D;
    logic [NBITS-1:0]       csrw_data_D;
    logic [N_OUT*NBITS-1:0] out_data;
    logic [N_OUT-1:0]       out_val;
    logic [N_OUT-1:0]       out_pending;
    logic [N_OUT-1:0]       out_ack;
    logic [N_OUT-1:0]       out_overrun;

    proc_csr_io_unit #(
        .NBITS(NBITS), .N_IN(N_IN), .N_OUT(N_OUT), .DEPTH(DEPTH), .SELW(SELW)
    ) dut (
        .clk(clk), .rst(rst), .pipe_en(pipe_en), .kill_X(kill_X),
        .csrr_sel_D(csrr_sel_D), .in_data(in_data), .csrr_data_X(csrr_data_X),
        .csrw_val_D(csrw_val_D), .csrw_sel_D(csrw_sel_D), .csrw_data_D(csrw_data_D),
        .out_data(out_data), .out_val(out_val), .out_pending(out_pending),
        .out_ack(out_ack), .out_overrun(out_overrun)
    );

    always #5 clk = ~clk;

    // Each in-flight write counts down the advancing edges it still needs
    typedef struct {
        int              left;
        logic [SELW-1:0] sel;
        logic [NBITS-1:0] data;
    } tok_t;

    tok_t                   q[$];
    logic [NBITS-1:0]       m_csrr = '0;
    logic [N_OUT*NBITS-1:0] m_data = '0;
    logic [N_OUT-1:0]       m_val  = '0;
    logic [N_OUT-1:0]       m_pend = '0;
    logic [N_OUT-1:0]       m_ovr  = '0;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [N_OUT-1:0] c;
        tok_t             t;
        int               idx;
        c = '0;
        if (rst) begin
            q.delete();
            m_csrr = '0; m_data = '0; m_val = '0; m_pend = '0; m_ovr = '0;
            return;
        end
        if (kill_X) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].left == DEPTH) q.delete(i);
            end
        end
        if (pipe_en) begin
            idx = int'(csrr_sel_D);
            if (idx < N_IN) m_csrr = in_data[idx*NBITS +: NBITS];
`ifdef CSR_IO_READBACK_EN
            else if (idx < N_IN + N_OUT) m_csrr = m_data[(idx-N_IN)*NBITS +: NBITS];
`endif
            else m_csrr = '0;
            for (int i = 0; i < q.size(); i++) q[i].left = q[i].left - 1;
            if (q.size() > 0 && q[0].left == 0) begin
                t = q.pop_front();
                if (int'(t.sel) < N_OUT) begin
                    c[t.sel] = 1'b1;
                    m_data[int'(t.sel)*NBITS +: NBITS] = t.data;
                end
            end
            if (csrw_val_D && !kill_X) begin
                t.left = DEPTH; t.sel = csrw_sel_D; t.data = csrw_data_D;
                q.push_back(t);
            end
        end
        for (int k = 0; k < N_OUT; k++) begin
            if (c[k] && out_ack[k]) begin
                m_pend[k] = 1'b1;
            end else if (c[k]) begin
                m_ovr[k]  = m_ovr[k] | m_pend[k];
                m_pend[k] = 1'b1;
            end else if (out_ack[k]) begin
                m_pend[k] = 1'b0;
                m_ovr[k]  = 1'b0;
            end
        end
        m_val = c;
    endtask

    // One clock: model follows the edge, DUT compared on the falling edge
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("csrr_data_X", 128'(csrr_data_X), 128'(m_csrr));
        chk("out_data",    128'(out_data),    128'(m_data));
        chk("out_val",     128'(out_val),     128'(m_val));
        chk("out_pending", 128'(out_pending), 128'(m_pend));
        chk("out_overrun", 128'(out_overrun), 128'(m_ovr));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic idle_inputs();
        kill_X = 1'b0; csrw_val_D = 1'b0; csrw_sel_D = '0; csrw_data_D = '0; out_ack = '0;
    endtask

    task automatic put_write(input int sel, input logic [NBITS-1:0] data);
        csrw_val_D = 1'b1; csrw_sel_D = SELW'(sel); csrw_data_D = data;
    endtask

    int pulses;
    int pulse_at;

    initial begin
        rst = 1'b1; pipe_en = 1'b1; csrr_sel_D = '0; in_data = '0;
        idle_inputs();
        ticks(2);
        rst = 1'b0;
        chk("reset_out_data", 128'(out_data), 128'(0));
        chk("reset_flags", 128'({out_val, out_pending, out_overrun}), 128'(0));
        chk("reset_csrr", 128'(csrr_data_X), 128'(0));

        // CSRR read of channel 1, then an out-of-range select
        in_data = {32'h3333_3333, 32'hCAFE_0001, 32'h1111_1111};
        csrr_sel_D = SELW'(1);
        tick();
        chk("csrr_ch1", 128'(csrr_data_X), 128'(32'hCAFE_0001));
        csrr_sel_D = SELW'(5);
        tick();
        chk("csrr_sel5", 128'(csrr_data_X), 128'(0));
        csrr_sel_D = SELW'(0);

        // Plain write to channel 2: visible four edges after D
        put_write(2, 32'h0000_00A5);
        tick();
        idle_inputs();
        ticks(2);
        chk("w2_not_yet", 128'(out_val), 128'(0));
        tick();
        chk("w2_data", 128'(out_data[2*NBITS +: NBITS]), 128'(32'h0000_00A5));
        chk("w2_val", 128'(out_val), 128'(3'b100));
        chk("w2_pend", 128'(out_pending[2]), 128'(1));
        tick();
        chk("w2_val_drop", 128'(out_val), 128'(0));
        out_ack = 3'b100;
        tick();
        out_ack = '0;

        // Same write stalled for two edges while in flight
        put_write(2, 32'h0000_005A);
        tick();
        idle_inputs();
        pulses = 0; pulse_at = 0;
        for (int i = 2; i <= 9; i++) begin
            pipe_en = (i == 2 || i == 3) ? 1'b0 : 1'b1;
            tick();
            if (out_val[2]) begin
                pulses++;
                pulse_at = i;
            end
        end
        pipe_en = 1'b1;
        chk("stall_pulses", 128'(pulses), 128'(1));
        chk("stall_pulse_at", 128'(pulse_at), 128'(6));
        chk("stall_data", 128'(out_data[2*NBITS +: NBITS]), 128'(32'h0000_005A));

        // Write to channel 0 squashed in X
        put_write(0, 32'h0000_0011);
        tick();
        idle_inputs();
        kill_X = 1'b1;
        tick();
        kill_X = 1'b0;
        ticks(4);
        chk("kill_data", 128'(out_data[0 +: NBITS]), 128'(0));
        chk("kill_pend", 128'(out_pending[0]), 128'(0));

        // Back-to-back writes to channel 1 without ack
        put_write(1, 32'h1); tick();
        put_write(1, 32'h2); tick();
        idle_inputs();
        ticks(3);
        chk("ovr_data", 128'(out_data[NBITS +: NBITS]), 128'(32'h2));
        chk("ovr_flag", 128'(out_overrun[1]), 128'(1));
        out_ack = 3'b010;
        tick();
        out_ack = '0;
        chk("ack_clears", 128'({out_pending[1], out_overrun[1]}), 128'(0));

        // Repeat with the ack landing on the second commit
        put_write(1, 32'h1); tick();
        put_write(1, 32'h2); tick();
        idle_inputs();
        ticks(2);
        out_ack = 3'b010;
        tick();
        out_ack = '0;
        chk("race_pend", 128'(out_pending[1]), 128'(1));
        chk("race_ovr", 128'(out_overrun[1]), 128'(0));
        chk("race_data", 128'(out_data[NBITS +: NBITS]), 128'(32'h2));

        // Reset with three writes in flight
        put_write(0, 32'hA0); tick();
        put_write(1, 32'hA1); tick();
        put_write(2, 32'hA2); tick();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ticks(5);
        chk("rst_flight", 128'({out_data, out_val, out_pending, out_overrun}), 128'(0));

`ifdef CSR_IO_READBACK_EN
        put_write(0, 32'h77);
        tick();
        idle_inputs();
        ticks(4);
        csrr_sel_D = SELW'(N_IN);
        tick();
        chk("readback", 128'(csrr_data_X), 128'(32'h77));
        csrr_sel_D = '0;
`endif

        // Mixed traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst         = ($urandom_range(0, 59) == 0);
            pipe_en     = ($urandom_range(0, 3) != 0);
            kill_X      = ($urandom_range(0, 7) == 0);
            csrw_val_D  = ($urandom_range(0, 1) == 1);
            csrw_sel_D  = SELW'($urandom_range(0, 7));
            csrw_data_D = $urandom;
            csrr_sel_D  = SELW'($urandom_range(0, 7));
            in_data     = {$urandom, $urandom, $urandom};
            out_ack     = N_OUT'($urandom_range(0, 7) & $urandom_range(0, 7));
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        ticks(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
